// File: rtl/trig_evt_pkg.sv
// Shared event-record definitions for the trigger event recorder.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
//
// Contents: event type codes, type width, pending-slot count and the
// record-width helper used to size the event FIFO.
package trig_evt_pkg;

  localparam int EVT_W   = 2;
  localparam int TOF_W   = 32;
  localparam int N_SLOTS = 3;

  typedef logic [EVT_W-1:0] evt_type_t;

  localparam evt_type_t EVT_P0  = 2'd0;  // detect_pls_0 rising
  localparam evt_type_t EVT_P1  = 2'd1;  // detect_pls_1 rising
  localparam evt_type_t EVT_END = 2'd2;  // detect_pls_1 falling
  // Code 3 is reserved and never produced.

  // Record layout is {type, timestamp, tof}.
  function automatic int rec_width(input int ts_width);
    return EVT_W + ts_width + TOF_W;
  endfunction

endpackage

// File: rtl/evt_fifo_fwft.sv
// First-word-fall-through FIFO: head word is visible on rd_data whenever !empty.
// Latency: write visible at the head the cycle after wr_en; pop takes effect at the edge.
// Backpressure: write refused when full unless a pop happens in the same cycle.
//
// Ports: clk, resetn (async active-low), clr (sync clear), wr_en/wr_data/full,
//        rd_en/rd_data/empty, count (occupancy, 0..DEPTH).
module evt_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd_en & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write can land there.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/trig_event_recorder.sv
// Turns trigger_gen detect strobes into timestamped {type, ts, tof} records in a FWFT FIFO.
// Latency: edge in cycle N -> pending end of N -> FIFO write end of N+1 -> rd_valid in N+2.
// Backpressure: none upstream; a full FIFO discards the head pending event and counts it.
//
// Ports: clk, resetn (async active-low), trig_enable (low = sync clear),
//        detect_pls_0/1 + pulse_tof from trigger_gen, rd_en pop strobe,
//        rd_valid/rd_type/rd_ts/rd_tof head record, fifo_count, overflow, drop_cnt.
module trig_event_recorder
  import trig_evt_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   trig_enable,
  input  logic                   detect_pls_0,
  input  logic                   detect_pls_1,
  input  logic [TOF_W-1:0]       pulse_tof,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [EVT_W-1:0]       rd_type,
  output logic [TS_WIDTH-1:0]    rd_ts,
  output logic [TOF_W-1:0]       rd_tof,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  localparam int REC_W = rec_width(TS_WIDTH);
  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;

  typedef struct packed {
    evt_type_t           typ;
    logic [TS_WIDTH-1:0] ts;
    logic [TOF_W-1:0]    tof;
  } evt_rec_t;

  logic                prev_p0;
  logic                prev_p1;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [N_SLOTS-1:0]  pend;
  logic [TS_WIDTH-1:0] slot_ts  [N_SLOTS];
  logic [TOF_W-1:0]    slot_tof [N_SLOTS];

  logic [N_SLOTS-1:0]  edge_hit;
  logic [N_SLOTS-1:0]  freed;
  logic [N_SLOTS-1:0]  held;
  logic [N_SLOTS-1:0]  capture;
  logic [N_SLOTS-1:0]  edge_drop;
  logic                pend_any;
  evt_type_t           sel;
  logic                fifo_pop;
  logic                accept;
  logic                full_drop;
  logic [2:0]          drop_inc;
  logic [16:0]         drop_sum;
  evt_rec_t            wr_rec;
  evt_rec_t            head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_wr;
  logic [REC_W-1:0]    fifo_rd_data;

  // Edges are only acted on while enabled, but prev_* always track the pins
  // so re-enabling never sees a stale level as an edge.
  assign edge_hit[EVT_P0]  = trig_enable &  detect_pls_0 & ~prev_p0;
  assign edge_hit[EVT_P1]  = trig_enable &  detect_pls_1 & ~prev_p1;
  assign edge_hit[EVT_END] = trig_enable & ~detect_pls_1 &  prev_p1;

  assign fifo_pop = rd_en & ~fifo_empty;
  assign accept   = ~fifo_full | fifo_pop;

  always_comb begin
    pend_any = |pend;
    sel      = EVT_P0;
    if      (pend[EVT_P0]) sel = EVT_P0;
    else if (pend[EVT_P1]) sel = EVT_P1;
    else if (pend[EVT_END]) sel = EVT_END;

    // The selected slot leaves this cycle whether it is written or discarded,
    // so it is free to take a new capture in the same cycle.
    freed = pend_any ? (3'b001 << sel) : 3'b000;
    held  = pend & ~freed;

    capture   = edge_hit & ~held;
    edge_drop = edge_hit &  held;
    full_drop = pend_any & ~accept;
    fifo_wr   = pend_any &  accept & trig_enable;

    drop_inc = {2'b00, edge_drop[0]} + {2'b00, edge_drop[1]}
             + {2'b00, edge_drop[2]} + {2'b00, full_drop};
    drop_sum = {1'b0, drop_cnt} + {14'd0, drop_inc};

    wr_rec.typ = sel;
    case (sel)
      EVT_P1: begin
        wr_rec.ts  = slot_ts[1];
        wr_rec.tof = slot_tof[1];
      end
      EVT_END: begin
        wr_rec.ts  = slot_ts[2];
        wr_rec.tof = slot_tof[2];
      end
      default: begin
        wr_rec.ts  = slot_ts[0];
        wr_rec.tof = slot_tof[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_p0  <= 1'b0;
      prev_p1  <= 1'b0;
      ts_cnt   <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_ts[i]  <= '0;
        slot_tof[i] <= '0;
      end
    end else begin
      prev_p0 <= detect_pls_0;
      prev_p1 <= detect_pls_1;
      if (!trig_enable) begin
        // Pending events are discarded here without counting as drops.
        ts_cnt   <= '0;
        pend     <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        ts_cnt <= ts_cnt + TS_ONE;
        pend   <= held | capture;
        if (drop_inc != 3'd0) overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        for (int i = 0; i < N_SLOTS; i++) begin
          if (capture[i]) begin
            slot_ts[i]  <= ts_cnt;
            slot_tof[i] <= pulse_tof;
          end
        end
      end
    end
  end

  evt_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (~trig_enable),
    .wr_en   (fifo_wr),
    .wr_data (wr_rec),
    .full    (fifo_full),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Head fields are forced to zero while empty so stale memory never shows.
  assign head     = fifo_rd_data;
  assign rd_valid = ~fifo_empty;
  assign rd_type  = rd_valid ? head.typ : '0;
  assign rd_ts    = rd_valid ? head.ts  : '0;
  assign rd_tof   = rd_valid ? head.tof : '0;

endmodule
